// File: rtl/ama_riscv_uart_if.sv
// Core-side MMIO bus of the UART: TX byte handshake toward the
// transmitter and RX byte/status handshake back to the core.
interface ama_riscv_uart_if;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;

  // Core side: issues TX bytes and pops RX bytes
  modport master (
    output data_in,
    output data_in_valid,
    output data_out_ready,
    input  data_in_ready,
    input  data_out,
    input  data_out_valid
  );

  // UART side: accepts TX bytes and presents RX bytes
  modport slave (
    input  data_in,
    input  data_in_valid,
    input  data_out_ready,
    output data_in_ready,
    output data_out,
    output data_out_valid
  );
endinterface

// File: rtl/ama_riscv_uart.sv
// 8N1 UART sitting behind the core's MMIO UART port.
// The TX and RX paths are independent FSMs sharing only the clock and
// reset. Every output comes straight from a register, so there is no
// combinational path from any input to any output.
// CLK_FREQ/BAUD_RATE must be at least 4 so that the half-bit delay used
// to centre RX sampling is non-zero.
module ama_riscv_uart #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic                  clk,
  input  logic                  rst,
  ama_riscv_uart_if.slave       bus,
  input  logic                  serial_in,
  output logic                  serial_out,
  output logic                  rx_frame_err,
  output logic                  rx_overrun
);

  localparam int CYC_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W       = $clog2(CYC_PER_BIT);

  // TX counts up to the last cycle of a bit; RX counts down to zero.
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYC_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CYC_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } txState_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rxState_t;

  // ---------------------------------------------------------------
  // Transmitter state
  // ---------------------------------------------------------------
  txState_t         r_txState;
  logic [CNT_W-1:0] r_txCnt;
  logic [2:0]       r_txBitIdx;
  logic [7:0]       r_txShift;
  logic             r_txOut;
  logic             r_txReady;

  // ---------------------------------------------------------------
  // Receiver state
  // ---------------------------------------------------------------
  logic             r_rxSync1;
  logic             r_rxSync2;
  logic             w_rxLine;
  rxState_t         r_rxState;
  logic [CNT_W-1:0] r_rxCnt;
  logic [2:0]       r_rxBitIdx;
  logic [7:0]       r_rxShift;
  logic [7:0]       r_rxData;
  logic             r_rxValid;
  logic             r_rxFrameErr;
  logic             r_rxOverrun;

  // TX FSM: serialises a latched byte as start, 8 data bits LSB first, stop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_txState  <= TX_IDLE;
      r_txCnt    <= CNT_ZERO;
      r_txBitIdx <= 3'd0;
      r_txShift  <= 8'h00;
      r_txOut    <= 1'b1;
      r_txReady  <= 1'b1;
    end else begin
      case (r_txState)
        TX_IDLE: begin
          r_txOut    <= 1'b1;
          r_txReady  <= 1'b1;
          r_txCnt    <= CNT_ZERO;
          r_txBitIdx <= 3'd0;
          if (bus.data_in_valid && r_txReady) begin
            r_txShift <= bus.data_in;
            r_txOut   <= 1'b0;
            r_txReady <= 1'b0;
            r_txState <= TX_START;
          end
        end

        TX_START: begin
          if (r_txCnt == BIT_LAST) begin
            r_txCnt   <= CNT_ZERO;
            r_txOut   <= r_txShift[0];
            r_txState <= TX_DATA;
          end else begin
            r_txCnt <= r_txCnt + CNT_ONE;
          end
        end

        TX_DATA: begin
          if (r_txCnt == BIT_LAST) begin
            r_txCnt <= CNT_ZERO;
            if (r_txBitIdx == 3'd7) begin
              r_txOut   <= 1'b1;
              r_txState <= TX_STOP;
            end else begin
              r_txBitIdx <= r_txBitIdx + 3'd1;
              r_txShift  <= {1'b0, r_txShift[7:1]};
              r_txOut    <= r_txShift[1];
            end
          end else begin
            r_txCnt <= r_txCnt + CNT_ONE;
          end
        end

        TX_STOP: begin
          if (r_txCnt == BIT_LAST) begin
            r_txCnt   <= CNT_ZERO;
            r_txReady <= 1'b1;
            r_txState <= TX_IDLE;
          end else begin
            r_txCnt <= r_txCnt + CNT_ONE;
          end
        end

        default: begin
          r_txState <= TX_IDLE;
          r_txOut   <= 1'b1;
          r_txReady <= 1'b1;
        end
      endcase
    end
  end

  // Two-flop synchroniser for the asynchronous RX pin; idles high
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxSync1 <= 1'b1;
      r_rxSync2 <= 1'b1;
    end else begin
      r_rxSync1 <= serial_in;
      r_rxSync2 <= r_rxSync1;
    end
  end

  assign w_rxLine = r_rxSync2;

  // RX FSM: centre-samples a frame and hands the byte to the core
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxState    <= RX_IDLE;
      r_rxCnt      <= CNT_ZERO;
      r_rxBitIdx   <= 3'd0;
      r_rxShift    <= 8'h00;
      r_rxData     <= 8'h00;
      r_rxValid    <= 1'b0;
      r_rxFrameErr <= 1'b0;
      r_rxOverrun  <= 1'b0;
    end else begin
      r_rxFrameErr <= 1'b0;
      if (r_rxValid && bus.data_out_ready) begin
        r_rxValid <= 1'b0;
      end

      case (r_rxState)
        RX_IDLE: begin
          r_rxBitIdx <= 3'd0;
          if (!w_rxLine) begin
            r_rxCnt   <= HALF_LAST;
            r_rxState <= RX_START;
          end
        end

        RX_START: begin
          if (r_rxCnt == CNT_ZERO) begin
            if (w_rxLine) begin
              r_rxState <= RX_IDLE;
            end else begin
              r_rxCnt   <= BIT_LAST;
              r_rxState <= RX_DATA;
            end
          end else begin
            r_rxCnt <= r_rxCnt - CNT_ONE;
          end
        end

        RX_DATA: begin
          if (r_rxCnt == CNT_ZERO) begin
            r_rxShift <= {w_rxLine, r_rxShift[7:1]};
            r_rxCnt   <= BIT_LAST;
            if (r_rxBitIdx == 3'd7) begin
              r_rxState <= RX_STOP;
            end else begin
              r_rxBitIdx <= r_rxBitIdx + 3'd1;
            end
          end else begin
            r_rxCnt <= r_rxCnt - CNT_ONE;
          end
        end

        RX_STOP: begin
          if (r_rxCnt == CNT_ZERO) begin
            r_rxState <= RX_IDLE;
            if (w_rxLine) begin
              r_rxData  <= r_rxShift;
              r_rxValid <= 1'b1;
              if (r_rxValid && !bus.data_out_ready) begin
                r_rxOverrun <= 1'b1;
              end
            end else begin
              r_rxFrameErr <= 1'b1;
            end
          end else begin
            r_rxCnt <= r_rxCnt - CNT_ONE;
          end
        end

        default: begin
          r_rxState <= RX_IDLE;
        end
      endcase
    end
  end

  assign serial_out         = r_txOut;
  assign bus.data_in_ready  = r_txReady;
  assign bus.data_out       = r_rxData;
  assign bus.data_out_valid = r_rxValid;
  assign rx_frame_err       = r_rxFrameErr;
  assign rx_overrun         = r_rxOverrun;

endmodule

// File: tb/tb_ama_riscv_uart.sv
// Bench for ama_riscv_uart at 10 clocks per bit: fixed TX/RX scenarios,
// randomised RX traffic against a byte-level receive model, and a
// loopback run with reset in the middle of a frame.
module tb_ama_riscv_uart;

  localparam int CLK_FREQ  = 100;
  localparam int BAUD_RATE = 10;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;

  logic clk = 1'b0;
  logic rst;
  logic rxDrive;
  logic loopback;
  logic serialIn;
  logic serialOut;
  logic frameErr;
  logic overrun;

  int testCount = 0;
  int failCount = 0;
  int errPulses = 0;

  // Receive model: what the core should see on the RX side
  logic [7:0] expData;
  logic       expValid;
  logic       expOverrun;
  int         expErr;

  ama_riscv_uart_if uartIf ();

  ama_riscv_uart #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (uartIf.slave),
    .serial_in   (serialIn),
    .serial_out  (serialOut),
    .rx_frame_err(frameErr),
    .rx_overrun  (overrun)
  );

  always #5 clk = ~clk;

  assign serialIn = loopback ? serialOut : rxDrive;

  // Count frame-error pulses, one per high cycle
  always @(negedge clk) begin
    if (frameErr) errPulses++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line level of a TX frame at a given cycle after the handshake
  function automatic logic expTxBit(input logic [7:0] b, input int cyc);
    int slot;
    slot = cyc / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    return 1'b1;
  endfunction

  task automatic modelReset();
    expData    = 8'h00;
    expValid   = 1'b0;
    expOverrun = 1'b0;
  endtask

  task automatic modelRxByte(input logic [7:0] b, input logic stopOk);
    if (stopOk) begin
      if (expValid) expOverrun = 1'b1;
      expData  = b;
      expValid = 1'b1;
    end else begin
      expErr++;
    end
  endtask

  task automatic checkRxState(input string tag);
    checkOutput({tag, "_data"}, uartIf.data_out, expData);
    checkOutput({tag, "_valid"}, uartIf.data_out_valid, expValid);
    checkOutput({tag, "_overrun"}, overrun, expOverrun);
    checkOutput({tag, "_errPulses"}, errPulses, expErr);
  endtask

  // Send one TX byte and follow the whole frame on serial_out
  task automatic applyTxByte(input logic [7:0] b, input logic holdValid);
    uartIf.data_in       = b;
    uartIf.data_in_valid = 1'b1;
    tick();
    if (!holdValid) uartIf.data_in_valid = 1'b0;
    for (int i = 0; i < 10 * CPB; i++) begin
      checkOutput("txBit", serialOut, expTxBit(b, i));
      checkOutput("txBusy", uartIf.data_in_ready, 1'b0);
      tick();
    end
    checkOutput("txIdleLine", serialOut, 1'b1);
    checkOutput("txReadyAgain", uartIf.data_in_ready, 1'b1);
  endtask

  // Drive one RX frame bit by bit; report the cycle valid rose, or -1
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit,
                               output int validCycle);
    logic [9:0] frame;
    logic       prevValid;
    frame      = {stopBit, b, 1'b0};
    validCycle = -1;
    prevValid  = uartIf.data_out_valid;
    for (int s = 0; s < 10; s++) begin
      for (int c = 0; c < CPB; c++) begin
        rxDrive = frame[s];
        tick();
        if (validCycle < 0 && uartIf.data_out_valid && !prevValid)
          validCycle = s * CPB + c;
        prevValid = uartIf.data_out_valid;
      end
    end
    rxDrive = 1'b1;
  endtask

  task automatic consumeRx();
    uartIf.data_out_ready = 1'b1;
    tick();
    uartIf.data_out_ready = 1'b0;
    expValid = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    int         vc;
    int         gap;
    int         seen;
    logic [7:0] b;
    logic       stopOk;

    rst                   = 1'b1;
    rxDrive               = 1'b1;
    loopback              = 1'b0;
    uartIf.data_in        = 8'h00;
    uartIf.data_in_valid  = 1'b0;
    uartIf.data_out_ready = 1'b0;
    expErr                = 0;
    modelReset();

    // Reset values
    doReset();
    checkOutput("rstSerialOut", serialOut, 1'b1);
    checkOutput("rstReady", uartIf.data_in_ready, 1'b1);
    checkOutput("rstDataOut", uartIf.data_out, 8'h00);
    checkOutput("rstValid", uartIf.data_out_valid, 1'b0);
    checkOutput("rstFrameErr", frameErr, 1'b0);
    checkOutput("rstOverrun", overrun, 1'b0);

    // TX single byte, then back-to-back with valid held high
    applyTxByte(8'hA5, 1'b0);
    tick();
    applyTxByte(8'h00, 1'b1);
    applyTxByte(8'hFF, 1'b0);
    for (int n = 0; n < 3; n++) begin
      tick();
      applyTxByte(8'($urandom_range(0, 255)), 1'b0);
    end

    // RX ideal frame with latency check, then a read
    tick();
    applyStimulus(8'h3C, 1'b1, vc);
    modelRxByte(8'h3C, 1'b1);
    checkOutput("rxLatency", vc, 97);
    checkRxState("rxIdeal");
    consumeRx();
    checkRxState("rxRead");

    // Short low glitch on an idle line, then a good byte
    rxDrive = 1'b0;
    repeat (3) tick();
    rxDrive = 1'b1;
    repeat (20) tick();
    checkRxState("rxGlitch");
    applyStimulus(8'h96, 1'b1, vc);
    modelRxByte(8'h96, 1'b1);
    checkRxState("rxAfterGlitch");
    consumeRx();

    // Stop bit low: one error pulse, nothing delivered
    repeat (4) tick();
    applyStimulus(8'h77, 1'b0, vc);
    modelRxByte(8'h77, 1'b0);
    repeat (10) tick();
    checkOutput("rxBadStopNoValid", vc, -1);
    checkRxState("rxBadStop");

    // Overrun: two bytes with no read in between
    applyStimulus(8'h11, 1'b1, vc);
    modelRxByte(8'h11, 1'b1);
    repeat (4) tick();
    applyStimulus(8'h22, 1'b1, vc);
    modelRxByte(8'h22, 1'b1);
    checkRxState("rxOverrun");
    consumeRx();
    repeat (4) tick();
    checkRxState("rxOverrunSticky");

    // Randomised RX traffic against the model
    for (int n = 0; n < 8; n++) begin
      gap = 4 + $urandom_range(0, 6);
      repeat (gap) tick();
      b      = 8'($urandom_range(0, 255));
      stopOk = ($urandom_range(0, 3) != 0);
      applyStimulus(b, stopOk, vc);
      modelRxByte(b, stopOk);
      repeat (10) tick();
      checkRxState("rxRandom");
      if ($urandom_range(0, 1) == 1) begin
        consumeRx();
        checkRxState("rxRandomRead");
      end
    end

    // Reset clears the sticky overrun
    doReset();
    checkRxState("rxAfterReset");

    // Loopback: TX feeds RX directly
    loopback = 1'b1;
    tick();
    applyTxByte(8'h5A, 1'b0);
    modelRxByte(8'h5A, 1'b1);
    checkRxState("loopback");
    consumeRx();

    // Reset during bit 4 of a second loopback byte
    tick();
    b                    = 8'($urandom_range(0, 255));
    uartIf.data_in       = b;
    uartIf.data_in_valid = 1'b1;
    tick();
    uartIf.data_in_valid = 1'b0;
    repeat (5 * CPB) tick();
    checkOutput("lbBit4", serialOut, b[4]);
    rst = 1'b1;
    tick();
    checkOutput("lbRstSerialOut", serialOut, 1'b1);
    checkOutput("lbRstReady", uartIf.data_in_ready, 1'b1);
    rst = 1'b0;
    modelReset();
    seen = 0;
    for (int i = 0; i < 15 * CPB; i++) begin
      tick();
      if (uartIf.data_out_valid) seen++;
    end
    checkOutput("lbNoSpuriousValid", seen, 0);
    checkRxState("lbAfterReset");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/ama_riscv_uart.md
Name: ama_riscv_uart

Overview:
- 8N1 UART peripheral directly downstream of the core's MMIO UART port.
- Consumes the core's store strobe and TX byte (store_to_uart, mmio_uart_data_in).
- Produces the RX byte and status the core reads back (mmio_uart_data_out, mmio_data_out_valid, mmio_data_in_ready), popped by load_from_uart.
- Drives/samples the board serial pins.

Parameters:
CLK_FREQ, 100_000_000, core clock frequency in Hz
BAUD_RATE, 115_200, line rate in baud
CYC_PER_BIT, CLK_FREQ/BAUD_RATE (integer divide), derived localparam, clocks per bit (868 at defaults); must be >= 4
CNT_W, $clog2(CYC_PER_BIT), derived localparam, baud counter width

Ports:
clk  input  1  core clock; single clock domain
rst  input  1  reset, synchronous, active-high
data_in  input  8  TX byte from core (mmio_uart_data_in)
data_in_valid  input  1  TX request (store_to_uart)
data_in_ready  output  1  transmitter idle, can accept (mmio_data_in_ready)
data_out  output  8  last received byte (mmio_uart_data_out)
data_out_valid  output  1  unread RX byte present (mmio_data_out_valid)
data_out_ready  input  1  core consumes RX byte (load_from_uart)
serial_in  input  1  RX pin, asynchronous
serial_out  output  1  TX pin
rx_frame_err  output  1  one-cycle pulse: stop bit sampled 0
rx_overrun  output  1  sticky: byte received while data_out_valid=1; cleared only by rst

Behaviour:
- Reset values: serial_out=1, data_in_ready=1, data_out=8'h00, data_out_valid=0, rx_frame_err=0, rx_overrun=0. Both FSMs go to IDLE and counters clear. Reset mid-frame aborts immediately; serial_out returns to 1 the next cycle.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: serial_out=1, data_in_ready=1. A handshake (valid & ready) latches data_in into the shift register and moves to START.
  - data_in_valid while ready=0 is ignored; no queueing.
  - START: serial_out=0 for CYC_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CYC_PER_BIT cycles; bit index counter 0..7.
  - STOP: serial_out=1 for CYC_PER_BIT cycles, then IDLE.
  - data_in_ready=0 from the cycle after the handshake through the last STOP cycle, and 1 again on IDLE entry.
  - Frame length is exactly 10*CYC_PER_BIT cycles from the first START cycle.
  - Back-to-back bytes are legal: valid held high is accepted on the first IDLE cycle, so there is exactly 1 idle-high cycle between frames.
  - serial_out is registered (no combinational glitch).
- RX path:
  - serial_in passes through a 2-FF synchronizer, reset to 1. Synchronizer latency is 2 cycles.
- RX FSM, states IDLE, START, DATA, STOP:
  - IDLE: synced line =0 moves to START and loads the counter with CYC_PER_BIT/2.
  - START: at half-bit, if line=1 it is a glitch; return to IDLE with no flags. Otherwise go to DATA with counter = CYC_PER_BIT.
  - DATA: sample at each full-bit expiry (bit centres) and shift in LSB first. After 8 samples go to STOP.
  - STOP: sample at centre.
    - If 1: data_out <= byte and data_out_valid <= 1 next cycle. If data_out_valid was already 1, overwrite data_out and set rx_overrun.
    - If 0: discard the byte, pulse rx_frame_err for 1 cycle, leave data_out/valid unchanged.
  - Return to IDLE right after the stop-bit centre sample. Do not wait for the end of the bit, so drift tolerance is preserved.
- RX read handshake:
  - data_out_valid & data_out_ready clears valid next cycle; data_out keeps its value.
  - Same-cycle completion of a new byte and consumption: the new byte wins, valid stays 1, no overrun.
- TX and RX are fully independent. Loopback (serial_out tied to serial_in) must work.
- No combinational path from any input to any output.

Test Plan:
- Bench uses CLK_FREQ=100, BAUD_RATE=10 (CYC_PER_BIT=10).
- TX single byte: rst 2 cycles, then data_in=8'hA5 with valid for 1 cycle -> serial_out is 0 for 10 cycles, then bits 1,0,1,0,0,1,0,1 (10 cycles each), then 1 for 10. data_in_ready is 0 for exactly 100 cycles and 1 again at cycle 101.
- TX back-to-back: valid held high with 8'h00 then 8'h FF -> two complete frames separated by exactly 1 idle-high cycle; the second frame's data bits are all 1.
- RX ideal frame: drive 8'h3C on serial_in at 10 cycles/bit -> data_out=8'h3C and data_out_valid=1 about 2+5+90 cycles after the start edge. No flags. Valid clears 1 cycle after a data_out_ready pulse.
- RX errors:
  - 3-cycle low glitch on idle serial_in -> no valid, no frame_err, FSM back in IDLE.
  - Frame with stop bit 0 -> rx_frame_err pulses for 1 cycle and data_out_valid stays 0.
- RX overrun: receive 8'h11 then 8'h22 without asserting data_out_ready -> data_out=8'h22, valid=1, rx_overrun=1 until rst.
- Loopback + reset: serial_out to serial_in, send 8'h5A -> received 8'h5A. Assert rst at TX bit 4 of a second byte -> next cycle serial_out=1 and data_in_ready=1, and no spurious RX valid after reset.
